// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the two-write-port register file.
package regfile_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int ZERO_ADDR  = 0;

   // Widest field / flattened bus the extractor handles (4 ports x 64 bits)
   localparam int FLD_W     = 64;
   localparam int FLD_BUS_W = 4 * FLD_W;

   function automatic logic [FLD_W-1:0] get_field(input logic [FLD_BUS_W-1:0] bus,
                                                  input int unsigned idx,
                                                  input int unsigned w);
      logic [FLD_BUS_W-1:0] mask;
      mask = (FLD_BUS_W'(1) << w) - FLD_BUS_W'(1);
      return FLD_W'((bus >> (idx * w)) & mask);
   endfunction
endpackage

// File: rtl/regfile_sb.sv
// Busy scoreboard: issue sets, write clears, issue wins; per-port rbusy masked by bypass.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [1:0]              wen,
   input  logic [ADDR_W-1:0]       waddr0,
   input  logic [ADDR_W-1:0]       waddr1,
   input  logic                    iss_en,
   input  logic [ADDR_W-1:0]       iss_addr,
   input  logic [NREAD*ADDR_W-1:0] raddr,
   output logic [NREAD-1:0]        rbusy
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] busy, busy_nxt;

   always_comb begin
      busy_nxt = busy;
      if (wen[0]) busy_nxt[waddr0] = 1'b0;
      if (wen[1]) busy_nxt[waddr1] = 1'b0;
      // A fresh producer outranks the write retiring the old one
      if (iss_en) busy_nxt[iss_addr] = 1'b1;
      if (ZERO_REG != 0) busy_nxt[ZERO_ADDR] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) busy <= '0;
      else         busy <= busy_nxt;
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rb
      logic [ADDR_W-1:0] ra;
      logic              wr_hit;
      assign ra     = ADDR_W'(get_field(FLD_BUS_W'(raddr), i, ADDR_W));
      assign wr_hit = (wen[0] && waddr0 == ra) || (wen[1] && waddr1 == ra);
      assign rbusy[i] = busy[ra] & ~wr_hit;
   end
endmodule

// File: rtl/regfile_2w.sv
// Two-write, NREAD-read register file with write bypass, busy scoreboard and debug port.
module regfile_2w
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [1:0]              wen,
   input  logic [ADDR_W-1:0]       waddr0,
   input  logic [ADDR_W-1:0]       waddr1,
   input  logic [DATA_W-1:0]       wdata0,
   input  logic [DATA_W-1:0]       wdata1,
   input  logic [NREAD*ADDR_W-1:0] raddr,
   output logic [NREAD*DATA_W-1:0] rdata,
   output logic [NREAD-1:0]        rbusy,
   input  logic                    iss_en,
   input  logic [ADDR_W-1:0]       iss_addr,
   input  logic [ADDR_W-1:0]       test_addr,
   output logic [DATA_W-1:0]       test_data
);
   localparam int                DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_ok0, wr_ok1;

   assign wr_ok0 = wen[0] && !(ZERO_REG != 0 && waddr0 == ZADDR);
   assign wr_ok1 = wen[1] && !(ZERO_REG != 0 && waddr1 == ZADDR);

   // Port 1 is assigned last so it wins a same-address collision
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      end else begin
         if (wr_ok0) regs[waddr0] <= wdata0;
         if (wr_ok1) regs[waddr1] <= wdata1;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      assign ra = ADDR_W'(get_field(FLD_BUS_W'(raddr), i, ADDR_W));
      always_comb begin
         rd = regs[ra];
         if (ZERO_REG != 0 && ra == ZADDR)  rd = '0;
         else if (wen[1] && waddr1 == ra)   rd = wdata1;
         else if (wen[0] && waddr0 == ra)   rd = wdata0;
      end
      assign rdata[i*DATA_W +: DATA_W] = rd;
   end

   assign test_data = (ZERO_REG != 0 && test_addr == ZADDR) ? '0 : regs[test_addr];

   regfile_sb #(
      .ADDR_W   (ADDR_W),
      .NREAD    (NREAD),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .resetn   (resetn),
      .wen      (wen),
      .waddr0   (waddr0),
      .waddr1   (waddr1),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .raddr    (raddr),
      .rbusy    (rbusy)
   );
endmodule

// File: tb/tb_regfile_2w.sv
// Directed bench for regfile_2w: reset, bypass, dual-write, zero register, scoreboard.
module tb_regfile_2w;
   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  wen;
   logic [4:0]  waddr0, waddr1;
   logic [31:0] wdata0, wdata1;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic [4:0]  test_addr;
   logic [31:0] test_data;

   int n_cmp = 0;
   int n_err = 0;

   regfile_2w dut (
      .clk       (clk),
      .resetn    (resetn),
      .wen       (wen),
      .waddr0    (waddr0),
      .waddr1    (waddr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .raddr     (raddr),
      .rdata     (rdata),
      .rbusy     (rbusy),
      .iss_en    (iss_en),
      .iss_addr  (iss_addr),
      .test_addr (test_addr),
      .test_data (test_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; checks happen 1 time unit later
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      wen = 2'b00; iss_en = 1'b0;
   endtask

   task automatic wr0(input logic [4:0] a, input logic [31:0] d);
      wen[0] = 1'b1; waddr0 = a; wdata0 = d;
   endtask

   task automatic wr1(input logic [4:0] a, input logic [31:0] d);
      wen[1] = 1'b1; waddr1 = a; wdata1 = d;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      raddr = {a1, a0};
   endtask

   initial begin
      resetn = 1'b0; wen = '0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
      raddr = '0; iss_en = 1'b0; iss_addr = '0; test_addr = '0;
      cyc(); cyc();
      resetn = 1'b1; rd(5'd5, 5'd6); test_addr = 5'd5;
      #1;
      chk("rst_test_data", test_data, 32'h0);
      chk("rst_rdata0",    rdata[31:0], 32'h0);
      chk("rst_rbusy",     32'(rbusy), 32'h0);

      // Reset clear
      cyc(); wr0(5'd5, 32'hDEADBEEF); iss_en = 1'b1; iss_addr = 5'd6;
      cyc(); idle(); #1;
      chk("pre_rst_r5",    test_data, 32'hDEADBEEF);
      chk("pre_rst_busy6", 32'(rbusy), 32'h2);
      cyc(); resetn = 1'b0; wr0(5'd5, 32'h11111111); iss_en = 1'b1; iss_addr = 5'd5;
      cyc(); resetn = 1'b1; idle(); #1;
      chk("post_rst_r5",    test_data, 32'h0);
      chk("post_rst_rdata", rdata[31:0], 32'h0);
      chk("post_rst_rbusy", 32'(rbusy), 32'h0);

      // Bypass
      cyc(); wr0(5'd7, 32'h12345678); rd(5'd7, 5'd0); test_addr = 5'd7; #1;
      chk("byp_rdata0",   rdata[31:0], 32'h12345678);
      chk("byp_test_old", test_data, 32'h0);
      cyc(); idle(); #1;
      chk("byp_test_new", test_data, 32'h12345678);
      chk("byp_rdata0_2", rdata[31:0], 32'h12345678);

      // Dual-write conflict, port 1 wins
      cyc(); wr0(5'd3, 32'h1); wr1(5'd3, 32'h2); rd(5'd0, 5'd3); test_addr = 5'd3; #1;
      chk("dw_byp_rdata1", rdata[63:32], 32'h2);
      cyc(); idle(); #1;
      chk("dw_array_r3", test_data, 32'h2);
      chk("dw_rdata1",   rdata[63:32], 32'h2);

      // Two different addresses bypass independently
      cyc(); wr0(5'd10, 32'hA); wr1(5'd11, 32'hB); rd(5'd10, 5'd11); #1;
      chk("dw_sep_rd0", rdata[31:0], 32'hA);
      chk("dw_sep_rd1", rdata[63:32], 32'hB);

      // Zero register
      cyc(); idle(); wr0(5'd0, 32'hFFFFFFFF); iss_en = 1'b1; iss_addr = 5'd0;
      rd(5'd0, 5'd0); test_addr = 5'd0; #1;
      chk("z_byp_rdata0", rdata[31:0], 32'h0);
      chk("z_rbusy_now",  32'(rbusy), 32'h0);
      cyc(); idle(); #1;
      chk("z_test_data",  test_data, 32'h0);
      chk("z_rdata1",     rdata[63:32], 32'h0);
      chk("z_rbusy_next", 32'(rbusy), 32'h0);

      // Scoreboard
      cyc(); iss_en = 1'b1; iss_addr = 5'd9; rd(5'd9, 5'd9); #1;
      chk("sb_iss_cycle", 32'(rbusy), 32'h0);
      cyc(); idle(); #1;
      chk("sb_next", 32'(rbusy), 32'h3);
      cyc(); cyc(); cyc(); #1;
      chk("sb_hold3", 32'(rbusy), 32'h3);
      cyc(); wr0(5'd9, 32'h99); #1;
      chk("sb_wr_cycle", 32'(rbusy), 32'h0);
      chk("sb_wr_rdata", rdata[31:0], 32'h99);
      cyc(); idle(); #1;
      chk("sb_cleared", 32'(rbusy), 32'h0);
      cyc(); iss_en = 1'b1; iss_addr = 5'd9; wr1(5'd9, 32'h77); #1;
      chk("sb_iw_cycle", 32'(rbusy), 32'h0);
      cyc(); idle(); #1;
      chk("sb_iss_wins", 32'(rbusy), 32'h3);
      chk("sb_iw_data",  rdata[63:32], 32'h77);

      // Re-issue while busy, one write clears it
      cyc(); iss_en = 1'b1; iss_addr = 5'd9;
      cyc(); idle(); wr0(5'd9, 32'h55);
      cyc(); idle(); #1;
      chk("sb_no_count", 32'(rbusy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
